// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 encodings, controller state type and
// the fixed constants used by the iterative multiply/divide unit.
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MULDIV_ITERS = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN   = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // rs1 is treated as signed for every op except the fully unsigned ones.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return !((f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU));
    endfunction

    // rs2 follows rs1, except MULHSU where only rs1 is signed.
    function automatic logic op_signed_b(input logic [2:0] f3);
        return op_signed_a(f3) && (f3 != F3_MULHSU);
    endfunction

endpackage

// File: rtl/riscv_muldiv_ctrl.sv
// Sequencing for the multiply/divide unit: IDLE -> CALC (32 iterations) -> DONE,
// with registered busy/done and one-cycle datapath strobes.
module riscv_muldiv_ctrl
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam logic [4:0] LAST_COUNT = 5'(MULDIV_ITERS - 1);

    muldiv_state_t state_q;
    muldiv_state_t state_d;
    logic [4:0]    count_q;
    logic [4:0]    count_d;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // finish marks the final iteration so the result register loads on the
    // same edge that enters DONE, making result valid alongside the done pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step    = 1'b1;
                count_d = count_q + 5'd1;
                if (count_q == LAST_COUNT) begin
                    finish  = 1'b1;
                    count_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/riscv_muldiv.sv
// RV32M iterative multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fixup and special cases at the end.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic load;
    logic step;
    logic finish;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   shreg_q;
    logic [2*XLEN-1:0] acc_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              div0_q;
    logic              ovf_q;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              is_div;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res_d;

    riscv_muldiv_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy),
        .done   (done)
    );

    assign a_neg  = op_signed_a(funct3) & A[XLEN-1];
    assign b_neg  = op_signed_b(funct3) & B[XLEN-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;
    assign is_div = op_q[2];

    // mcand_q holds the multiplicand (or divisor); shreg_q holds the multiplier
    // shifting right (or the dividend shifting its MSB into the remainder).
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (shreg_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_q[2*XLEN-1:XLEN], shreg_q[XLEN-1]};
        diff    = rem_sh - {1'b0, mcand_q};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod  = (a_neg_q ^ b_neg_q) ? -acc_next : acc_next;
        quot  = acc_next[XLEN-1:0];
        rem   = acc_next[2*XLEN-1:XLEN];
        res_d = '0;
        case (op_q)
            F3_MUL: begin
                res_d = prod[XLEN-1:0];
            end
            F3_MULH, F3_MULHSU, F3_MULHU: begin
                res_d = prod[2*XLEN-1:XLEN];
            end
            F3_DIV, F3_DIVU: begin
                if (div0_q) begin
                    res_d = DIV0_QUOT;
                end else if (ovf_q) begin
                    res_d = INT_MIN;
                end else begin
                    res_d = (a_neg_q ^ b_neg_q) ? -quot : quot;
                end
            end
            default: begin
                // The remainder always carries the dividend's sign.
                if (div0_q) begin
                    res_d = a_raw_q;
                end else if (ovf_q) begin
                    res_d = '0;
                end else begin
                    res_d = a_neg_q ? -rem : rem;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_raw_q <= '0;
            mcand_q <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            result  <= '0;
        end else if (load) begin
            op_q    <= funct3;
            a_raw_q <= A;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            div0_q  <= (B == '0);
            ovf_q   <= funct3[2] && op_signed_b(funct3) && (A == INT_MIN) && (B == '1);
            mcand_q <= funct3[2] ? b_mag : a_mag;
            shreg_q <= funct3[2] ? a_mag : b_mag;
            acc_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_next;
            shreg_q <= is_div ? {shreg_q[XLEN-2:0], 1'b0} : {1'b0, shreg_q[XLEN-1:1]};
            if (finish) begin
                result <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv: directed RV32M cases, handshake/abort scenarios and
// randomized operations checked against a plain-arithmetic reference model.
module tb_riscv_muldiv;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (a_op),
        .B      (b_op),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: 64-bit native arithmetic plus the RISC-V special-case rules.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = 0;
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge in IDLE; drives one request and follows it for 36 cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string tag);
        int          done_cyc;
        int          done_cnt;
        int          busy_bad;
        logic [31:0] res33;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        res33    = '0;
        funct3 = f3;
        a_op   = a;
        b_op   = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        a_op   = $urandom;
        b_op   = $urandom;
        for (int c = 1; c <= 36; c++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy !== (c <= 33)) busy_bad++;
            if (c == 33) res33 = result;
            if (c < 36) @(negedge clk);
        end
        check({tag, " result"}, res33, exp_res);
        check({tag, " held"}, result, exp_res);
        check({tag, " done_cycle"}, 32'(done_cyc), 32'd33);
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_window"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int          d_cyc;
        int          d_cnt;
        int          b_cnt;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        a_op   = '0;
        b_op   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
        run_op(F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh_min");
        run_op(F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        run_op(F3_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, "mulhsu_m1_2");
        run_op(F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_m7_2");
        run_op(F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_m7_2");
        run_op(F3_DIVU,   32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, "divu_m7_2");
        run_op(F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, "divu_by0");
        run_op(F3_REMU,   32'd5,          32'd0,        32'd5,        "remu_by0");
        run_op(F3_DIV,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, "div_neg_by0");
        run_op(F3_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, "rem_neg_by0");
        run_op(F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h0,        "rem_ovf");

        // Start pulses while busy and in the done cycle are both ignored.
        funct3 = F3_DIV;
        a_op   = 32'd100;
        b_op   = 32'd7;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        d_cyc  = -1;
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) begin
                start  = 1'b1;
                funct3 = F3_MUL;
                a_op   = 32'd9;
                b_op   = 32'd9;
            end
            if (c == 6) start = 1'b0;
            if ((done === 1'b1) && (d_cyc < 0)) d_cyc = c;
            if (c < 33) @(negedge clk);
        end
        check("ignore_busy done_cycle", 32'(d_cyc), 32'd33);
        check("ignore_busy result", result, 32'd14);
        start  = 1'b1;
        funct3 = F3_MUL;
        a_op   = 32'd5;
        b_op   = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done ignored busy", 32'(busy), 32'd0);
        check("start_in_done result kept", result, 32'd14);
        run_op(F3_REMU, 32'd100, 32'd7, 32'd2, "back_to_back_remu");

        // Reset in the middle of a multiply aborts it without a done pulse.
        funct3 = F3_MUL;
        a_op   = 32'h1234;
        b_op   = 32'h5678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        d_cnt = 0;
        b_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) d_cnt++;
            if (busy !== 1'b0) b_cnt++;
        end
        check("abort no_done", 32'(d_cnt), 32'd0);
        check("abort stays_idle", 32'(b_cnt), 32'd0);
        run_op(F3_MUL, 32'd3, 32'd4, 32'd12, "mul_after_abort");

        // Reset and start together: the request is dropped.
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = F3_MUL;
        a_op   = 32'd2;
        b_op   = 32'd2;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start still_idle", 32'(busy), 32'd0);
        check("rst_start result", result, 32'd0);

        for (int i = 0; i < 48; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rf3, ra, rb, ref_op(rf3, ra, rb),
                   $sformatf("rand%0d f3=%0d a=%h b=%h", i, rf3, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
